// File: rtl/scfifo_pkg.sv
// Constants and width helper shared by the single-clock FIFO family.
package scfifo_pkg;

  localparam int unsigned RAM_RD_LATENCY      = 2;
  localparam int unsigned WR_TO_VALID_LATENCY = 3;

  // Bits needed to hold any count in 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) <= 64'(depth)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/generic_m20k.sv
// Behavioural simple-dual-port M20K: registered read address and registered output,
// both stages clock-enabled by re.
module generic_m20k #(
  parameter int unsigned WIDTH             = 8,
  parameter int unsigned ADDR_WIDTH        = 8,
  parameter string       FAMILY            = "Other",
  parameter int unsigned ENABLE_ECC        = 0,
  parameter int unsigned READ_INPUT_ENABLE = 1,
  parameter int unsigned READ_OUTPUT_REG   = 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      din,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      dout
);

  localparam bit HW_ECC = (ENABLE_ECC != 0) && (FAMILY != "Other");

  logic [WIDTH-1:0]      mem [1 << ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [WIDTH-1:0]      rdata;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
  end

  if (READ_INPUT_ENABLE != 0) begin : g_in_en
    always_ff @(posedge clk) begin
      if (re) raddr_q <= raddr;
    end
  end else begin : g_in_free
    always_ff @(posedge clk) raddr_q <= raddr;
  end

  assign rdata = mem[raddr_q];

  if (READ_OUTPUT_REG != 0) begin : g_out_reg
    logic [WIDTH-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (re) dout_q <= rdata;
    end
    assign dout = dout_q;
  end else begin : g_out_comb
    assign dout = rdata;
  end

  // ECC is not modelled; the data path is identical for every family here.
  if (HW_ECC) begin : g_ecc_unmodelled
  end

endmodule

// File: rtl/scfifo_m20k.sv
// Show-ahead FIFO: controller plus one M20K instance.
module scfifo_m20k
  import scfifo_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter string       FAMILY     = "Other"
) (
  input  logic                                    clk,
  input  logic                                    sclr,
  input  logic                                    wr_en,
  input  logic [WIDTH-1:0]                        wr_data,
  input  logic                                    rd_en,
  output logic [WIDTH-1:0]                        dout,
  output logic                                    dout_valid,
  output logic                                    full,
  output logic [count_width(1 << ADDR_WIDTH)-1:0] usedw,
  output logic                                    overflow,
  output logic                                    underflow
);

  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic                  ram_we;
  logic                  ram_re;
  logic [WIDTH-1:0]      ram_din;
  logic [WIDTH-1:0]      ram_q;

  m20k_scfifo_ctrl #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ctrl (
    .clk        (clk),
    .sclr       (sclr),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .full       (full),
    .usedw      (usedw),
    .overflow   (overflow),
    .underflow  (underflow),
    .ram_waddr  (ram_waddr),
    .ram_we     (ram_we),
    .ram_din    (ram_din),
    .ram_raddr  (ram_raddr),
    .ram_re     (ram_re),
    .ram_q      (ram_q)
  );

  generic_m20k #(
    .WIDTH             (WIDTH),
    .ADDR_WIDTH        (ADDR_WIDTH),
    .FAMILY            (FAMILY),
    .ENABLE_ECC        (0),
    .READ_INPUT_ENABLE (1),
    .READ_OUTPUT_REG   (1)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .din   (ram_din),
    .re    (ram_re),
    .raddr (ram_raddr),
    .dout  (ram_q)
  );

endmodule

// File: rtl/m20k_scfifo_ctrl.sv
// Show-ahead single-clock FIFO controller for a 2-cycle registered-read M20K.
// Occupancy counts words still travelling through the RAM read pipeline.
module m20k_scfifo_ctrl
  import scfifo_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                                           clk,
  input  logic                                           sclr,
  input  logic                                           wr_en,
  input  logic [WIDTH-1:0]                               wr_data,
  input  logic                                           rd_en,
  output logic [WIDTH-1:0]                               dout,
  output logic                                           dout_valid,
  output logic                                           full,
  output logic [count_width(1 << ADDR_WIDTH)-1:0]        usedw,
  output logic                                           overflow,
  output logic                                           underflow,
  output logic [ADDR_WIDTH-1:0]                          ram_waddr,
  output logic                                           ram_we,
  output logic [WIDTH-1:0]                               ram_din,
  output logic [ADDR_WIDTH-1:0]                          ram_raddr,
  output logic                                           ram_re,
  input  logic [WIDTH-1:0]                               ram_q
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned UW    = count_width(DEPTH);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] iptr_q, iptr_d;
  logic          v1_q, v1_d;
  logic          v2_q, v2_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic [PW-1:0] avail;
  logic [PW-1:0] occ;
  logic          full_c;
  logic          advance;
  logic          issue;
  logic          we_c;

  always_comb begin
    avail   = wptr_q - iptr_q;
    occ     = avail + PW'(v1_q) + PW'(v2_q);
    full_c  = (occ == PW'(DEPTH));
    // Both RAM read stages move together; they stall only while a valid head waits.
    advance = !v2_q || rd_en;
    issue   = advance && (avail != '0);
    we_c    = wr_en && !full_c && !sclr;

    wptr_d      = wptr_q + PW'(we_c);
    iptr_d      = iptr_q + PW'(issue);
    v1_d        = advance ? issue : v1_q;
    v2_d        = advance ? v1_q  : v2_q;
    overflow_d  = wr_en && full_c;
    underflow_d = rd_en && !v2_q;
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      wptr_q      <= '0;
      iptr_q      <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      iptr_q      <= iptr_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign usedw      = UW'(occ);
  assign full       = full_c;
  assign dout_valid = v2_q;
  assign dout       = ram_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign ram_we     = we_c;
  assign ram_waddr  = wptr_q[ADDR_WIDTH-1:0];
  assign ram_din    = wr_data;
  assign ram_raddr  = iptr_q[ADDR_WIDTH-1:0];
  assign ram_re     = advance;

endmodule
